// File: rtl/ram_2port_clr.sv
// Simple dual-port RAM with per-byte write enables and a hardware clear sweep.
// Define RAM_2PORT_OUT_REG_EN to add an output register stage (read latency 2 instead of 1).
module ram_2port_clr #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 16,
    parameter int INIT_CLEAR = 1
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst,
    input  logic                     i_Wr_DV,
    input  logic [$clog2(DEPTH)-1:0] i_Wr_Addr,
    input  logic [WIDTH-1:0]         i_Wr_Data,
    input  logic [WIDTH/8-1:0]       i_Wr_BE,
    input  logic                     i_Rd_En,
    input  logic [$clog2(DEPTH)-1:0] i_Rd_Addr,
    output logic                     o_Rd_DV,
    output logic [WIDTH-1:0]         o_Rd_Data,
    input  logic                     i_Clear,
    output logic                     o_Busy,
    output logic                     o_Drop
);

    localparam int            AW      = $clog2(DEPTH);
    localparam int            NB      = WIDTH / 8;
    localparam logic [AW:0]   DEPTH_A = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t           state_q;
    logic [AW-1:0]    sweep_q;
    logic             rd_dv_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             drop_q;
    logic             drop_d;
    logic             wr_in_range;
    logic             rd_in_range;

    logic [WIDTH-1:0] mem [DEPTH];

    // Address widths are rounded up, so non-power-of-two depths leave unmapped codes.
    assign wr_in_range = ({1'b0, i_Wr_Addr} < DEPTH_A);
    assign rd_in_range = ({1'b0, i_Rd_Addr} < DEPTH_A);

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        drop_d = 1'b0;
        if (state_q == ST_CLEAR) begin
            drop_d = i_Wr_DV | i_Rd_En;
        end else begin
            drop_d = (i_Wr_DV & ~wr_in_range) | (i_Rd_En & ~rd_in_range);
        end
    end

    // NOTE: sequential state uses non-blocking (<=) assignments so all registers update together.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q   <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_IDLE;
            sweep_q   <= '0;
            rd_dv_q   <= 1'b0;
            rd_data_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            drop_q  <= drop_d;
            rd_dv_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_Clear) begin
                        state_q <= ST_CLEAR;
                        sweep_q <= '0;
                    end
                    if (i_Rd_En) begin
                        rd_dv_q   <= 1'b1;
                        rd_data_q <= rd_in_range ? mem[i_Rd_Addr] : '0;
                    end
                end
                ST_CLEAR: begin
                    if (sweep_q == LAST_A) begin
                        state_q <= ST_IDLE;
                    end else begin
                        sweep_q <= sweep_q + AW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the array has no reset; a clear sweep is the only way to zero it.
    always_ff @(posedge i_Clk) begin
        if (state_q == ST_CLEAR) begin
            mem[sweep_q] <= '0;
        end else if (i_Wr_DV && wr_in_range) begin
            for (int k = 0; k < NB; k++) begin
                if (i_Wr_BE[k]) begin
                    mem[i_Wr_Addr][8*k +: 8] <= i_Wr_Data[8*k +: 8];
                end
            end
        end
    end

`ifdef RAM_2PORT_OUT_REG_EN
    logic             out_dv_q;
    logic [WIDTH-1:0] out_data_q;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            out_dv_q   <= 1'b0;
            out_data_q <= '0;
        end else begin
            out_dv_q <= rd_dv_q;
            if (rd_dv_q) begin
                out_data_q <= rd_data_q;
            end
        end
    end

    assign o_Rd_DV   = out_dv_q;
    assign o_Rd_Data = out_data_q;
`else
    assign o_Rd_DV   = rd_dv_q;
    assign o_Rd_Data = rd_data_q;
`endif

    assign o_Busy = (state_q == ST_CLEAR);
    assign o_Drop = drop_q;

endmodule

// File: tb/tb_ram_2port_clr.sv
// Directed bench for ram_2port_clr: a DEPTH=4 instance with power-up clear and a
// DEPTH=6 instance without it, used for out-of-range addresses and odd sweep length.
module tb_ram_2port_clr;

`ifdef RAM_2PORT_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;

    logic        a_wr_dv, a_rd_en, a_clear, a_rd_dv, a_busy, a_drop;
    logic [1:0]  a_wr_addr, a_rd_addr, a_wr_be;
    logic [15:0] a_wr_data, a_rd_data;

    logic        b_wr_dv, b_rd_en, b_clear, b_rd_dv, b_busy, b_drop;
    logic [2:0]  b_wr_addr, b_rd_addr;
    logic [1:0]  b_wr_be;
    logic [15:0] b_wr_data, b_rd_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_2port_clr #(.WIDTH(16), .DEPTH(4), .INIT_CLEAR(1)) u_a (
        .i_Clk(clk), .i_Rst(rst),
        .i_Wr_DV(a_wr_dv), .i_Wr_Addr(a_wr_addr), .i_Wr_Data(a_wr_data), .i_Wr_BE(a_wr_be),
        .i_Rd_En(a_rd_en), .i_Rd_Addr(a_rd_addr),
        .o_Rd_DV(a_rd_dv), .o_Rd_Data(a_rd_data),
        .i_Clear(a_clear), .o_Busy(a_busy), .o_Drop(a_drop)
    );

    ram_2port_clr #(.WIDTH(16), .DEPTH(6), .INIT_CLEAR(0)) u_b (
        .i_Clk(clk), .i_Rst(rst),
        .i_Wr_DV(b_wr_dv), .i_Wr_Addr(b_wr_addr), .i_Wr_Data(b_wr_data), .i_Wr_BE(b_wr_be),
        .i_Rd_En(b_rd_en), .i_Rd_Addr(b_rd_addr),
        .o_Rd_DV(b_rd_dv), .o_Rd_Data(b_rd_data),
        .i_Clear(b_clear), .o_Busy(b_busy), .o_Drop(b_drop)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input logic [1:0] addr, input logic [15:0] data, input logic [1:0] be);
        a_wr_dv = 1'b1; a_wr_addr = addr; a_wr_data = data; a_wr_be = be;
        tick();
        a_wr_dv = 1'b0;
    endtask

    task automatic a_read(input logic [1:0] addr, input logic [15:0] exp, input string name);
        a_rd_en = 1'b1; a_rd_addr = addr;
        tick();
        a_rd_en = 1'b0;
        for (int k = 1; k < LAT; k++) tick();
        checks++;
        if (a_rd_dv !== 1'b1 || a_rd_data !== exp) begin
            errors++;
            $display("FAIL %s: got dv=%b data=%h, want dv=1 data=%h", name, a_rd_dv, a_rd_data, exp);
        end
    endtask

    task automatic b_read(input logic [2:0] addr, input logic [15:0] exp, input string name);
        b_rd_en = 1'b1; b_rd_addr = addr;
        tick();
        b_rd_en = 1'b0;
        for (int k = 1; k < LAT; k++) tick();
        checks++;
        if (b_rd_dv !== 1'b1 || b_rd_data !== exp) begin
            errors++;
            $display("FAIL %s: got dv=%b data=%h, want dv=1 data=%h", name, b_rd_dv, b_rd_data, exp);
        end
    endtask

    task automatic test_reset();
        logic exp_busy;
        rst = 1'b1;
        a_wr_dv = 0; a_wr_addr = 0; a_wr_data = 0; a_wr_be = 0; a_rd_en = 0; a_rd_addr = 0; a_clear = 0;
        b_wr_dv = 0; b_wr_addr = 0; b_wr_data = 0; b_wr_be = 0; b_rd_en = 0; b_rd_addr = 0; b_clear = 0;
        tick();
        tick();
        checks++;
        if (a_rd_dv !== 1'b0 || a_rd_data !== 16'h0 || a_drop !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got dv=%b data=%h drop=%b, want 0 0000 0", a_rd_dv, a_rd_data, a_drop);
        end
        checks++;
        if (a_busy !== 1'b1 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got a=%b b=%b, want a=1 b=0", a_busy, b_busy);
        end
        rst = 1'b0;
        checks++;
        if (a_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_at_release: got %b, want 1", a_busy);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_busy = (i < 3);
            checks++;
            if (a_busy !== exp_busy) begin
                errors++;
                $display("FAIL init_sweep_busy[%0d]: got %b, want %b", i, a_busy, exp_busy);
            end
        end
        for (int i = 0; i < 4; i++) a_read(2'(i), 16'h0000, "init_zero");
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_d [4];
        int idx;
        exp_d[0] = 16'h1111; exp_d[1] = 16'h2222; exp_d[2] = 16'h3333; exp_d[3] = 16'h4444;
        for (int i = 0; i < 4; i++) a_write(2'(i), exp_d[i], 2'b11);
        for (int cyc = 0; cyc <= 3 + LAT; cyc++) begin
            if (cyc < 4) begin
                a_rd_en = 1'b1; a_rd_addr = 2'(cyc);
            end else begin
                a_rd_en = 1'b0;
            end
            tick();
            idx = cyc - (LAT - 1);
            checks++;
            if (idx >= 0 && idx < 4) begin
                if (a_rd_dv !== 1'b1 || a_rd_data !== exp_d[idx]) begin
                    errors++;
                    $display("FAIL b2b_read[%0d]: got dv=%b data=%h, want dv=1 data=%h", idx, a_rd_dv, a_rd_data, exp_d[idx]);
                end
            end else if (a_rd_dv !== 1'b0) begin
                errors++;
                $display("FAIL b2b_idle cyc %0d: got dv=%b, want 0", cyc, a_rd_dv);
            end
        end
    endtask

    task automatic test_byte_enable();
        a_write(2'd2, 16'hAB55, 2'b10);
        a_read(2'd2, 16'hAB33, "be_upper_byte");
        a_write(2'd2, 16'hFFFF, 2'b00);
        checks++;
        if (a_drop !== 1'b0) begin
            errors++;
            $display("FAIL be_zero_drop: got %b, want 0", a_drop);
        end
        a_read(2'd2, 16'hAB33, "be_zero_unchanged");
    endtask

    task automatic test_read_first();
        a_wr_dv = 1'b1; a_wr_addr = 2'd1; a_wr_data = 16'h7777; a_wr_be = 2'b11;
        a_rd_en = 1'b1; a_rd_addr = 2'd1;
        tick();
        a_wr_dv = 1'b0; a_rd_en = 1'b0;
        for (int k = 1; k < LAT; k++) tick();
        checks++;
        if (a_rd_dv !== 1'b1 || a_rd_data !== 16'h2222) begin
            errors++;
            $display("FAIL read_first_old: got dv=%b data=%h, want dv=1 data=2222", a_rd_dv, a_rd_data);
        end
        a_read(2'd1, 16'h7777, "read_first_new");
    endtask

    task automatic test_clear();
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        checks++;
        if (a_busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_busy_start: got %b, want 1", a_busy);
        end
        a_wr_dv = 1'b1; a_wr_addr = 2'd3; a_wr_data = 16'hFFFF; a_wr_be = 2'b11;
        tick();
        a_wr_dv = 1'b0;
        checks++;
        if (a_drop !== 1'b1 || a_rd_dv !== 1'b0) begin
            errors++;
            $display("FAIL clear_write_drop: got drop=%b dv=%b, want drop=1 dv=0", a_drop, a_rd_dv);
        end
        a_rd_en = 1'b1; a_rd_addr = 2'd3;
        tick();
        a_rd_en = 1'b0;
        checks++;
        if (a_drop !== 1'b1 || a_rd_dv !== 1'b0) begin
            errors++;
            $display("FAIL clear_read_drop: got drop=%b dv=%b, want drop=1 dv=0", a_drop, a_rd_dv);
        end
        tick();
        checks++;
        if (a_drop !== 1'b0 || a_rd_dv !== 1'b0 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_mid: got drop=%b dv=%b busy=%b, want 0 0 1", a_drop, a_rd_dv, a_busy);
        end
        tick();
        checks++;
        if (a_busy !== 1'b0 || a_rd_dv !== 1'b0) begin
            errors++;
            $display("FAIL clear_end: got busy=%b dv=%b, want 0 0", a_busy, a_rd_dv);
        end
        for (int i = 0; i < 4; i++) a_read(2'(i), 16'h0000, "clear_zero");
    endtask

    task automatic test_reset_mid_sweep();
        logic exp_busy;
        a_write(2'd3, 16'h5555, 2'b11);
        a_read(2'd3, 16'h5555, "pre_abort_read");
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (a_rd_dv !== 1'b0 || a_rd_data !== 16'h0 || a_drop !== 1'b0 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_reset_vals: got dv=%b data=%h drop=%b busy=%b, want 0 0000 0 1",
                     a_rd_dv, a_rd_data, a_drop, a_busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_clear = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 2) a_clear = 1'b0;
            exp_busy = (i < 3);
            checks++;
            if (a_busy !== exp_busy) begin
                errors++;
                $display("FAIL restart_busy[%0d]: got %b, want %b", i, a_busy, exp_busy);
            end
        end
        a_read(2'd3, 16'h0000, "restart_cleared");
    endtask

    task automatic test_out_of_range();
        logic exp_busy;
        b_wr_dv = 1'b1; b_wr_addr = 3'd5; b_wr_data = 16'h1234; b_wr_be = 2'b11;
        tick();
        b_wr_dv = 1'b0;
        checks++;
        if (b_drop !== 1'b0) begin
            errors++;
            $display("FAIL oor_valid_write_drop: got %b, want 0", b_drop);
        end
        b_read(3'd5, 16'h1234, "oor_last_word");
        b_wr_dv = 1'b1; b_wr_addr = 3'd6; b_wr_data = 16'hBEEF; b_wr_be = 2'b11;
        tick();
        b_wr_dv = 1'b0;
        checks++;
        if (b_drop !== 1'b1) begin
            errors++;
            $display("FAIL oor_write_drop: got %b, want 1", b_drop);
        end
        b_rd_en = 1'b1; b_rd_addr = 3'd7;
        tick();
        b_rd_en = 1'b0;
        checks++;
        if (b_drop !== 1'b1) begin
            errors++;
            $display("FAIL oor_read_drop: got %b, want 1", b_drop);
        end
        for (int k = 1; k < LAT; k++) tick();
        checks++;
        if (b_rd_dv !== 1'b1 || b_rd_data !== 16'h0000) begin
            errors++;
            $display("FAIL oor_read_data: got dv=%b data=%h, want dv=1 data=0000", b_rd_dv, b_rd_data);
        end
        b_clear = 1'b1;
        tick();
        b_clear = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_busy = (i < 5);
            checks++;
            if (b_busy !== exp_busy) begin
                errors++;
                $display("FAIL depth6_sweep_busy[%0d]: got %b, want %b", i, b_busy, exp_busy);
            end
        end
        b_read(3'd5, 16'h0000, "depth6_cleared");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_byte_enable();
        test_read_first();
        test_clear();
        test_reset_mid_sweep();
        test_out_of_range();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
